// File: rtl/raster_pkg.sv
// Shared types and constants for the synthetic raster pattern source.
package raster_pkg;
  localparam int PIX_W = 12;
  localparam int CNT_W = 11;

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;
  typedef enum logic [1:0] {PAT_HRAMP, PAT_VRAMP, PAT_CHECK, PAT_BARS} pattern_t;

  // Colour bars left to right, each entry encoded {R,G,B}.
  localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                          3'b101, 3'b100, 3'b001, 3'b000};
endpackage

// File: rtl/raster_pattern_source_if.sv
// Camera-style pixel stream: run controls in, registered raster out.
interface raster_pattern_source_if;
  import raster_pkg::*;

  logic             en;
  logic [1:0]       pattern;
  logic [PIX_W-1:0] data;
  logic             dval;
  logic             fval;
  logic [CNT_W-1:0] x_cont;
  logic [CNT_W-1:0] y_cont;
  logic [15:0]      frame;

  modport master (input en, pattern, output data, dval, fval, x_cont, y_cont, frame);
  modport slave  (output en, pattern, input data, dval, fval, x_cont, y_cont, frame);
endinterface

// File: rtl/raster_pattern_source_pattern_pixel.sv
// Combinational pixel generator: maps pattern, coordinates and bar index to a value.
module pattern_pixel
  import raster_pkg::*;
#(
  parameter int CHK_BIT = 5
) (
  input  pattern_t         pat,
  input  logic [CNT_W-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  logic [2:0]       bar_idx,
  output logic [PIX_W-1:0] pix
);

  logic [2:0] rgb;
  logic       comp;

  always_comb begin
    rgb  = BAR_RGB[bar_idx];
    comp = 1'b0;
    // Bayer site: even row G R G R..., odd row B G B G...
    case ({y[0], x[0]})
      2'b00:   comp = rgb[1];
      2'b01:   comp = rgb[2];
      2'b10:   comp = rgb[0];
      default: comp = rgb[1];
    endcase

    pix = '0;
    case (pat)
      PAT_HRAMP: pix = {x, 1'b0};
      PAT_VRAMP: pix = {y, 1'b0};
      PAT_CHECK: pix = {PIX_W{x[CHK_BIT] ^ y[CHK_BIT]}};
      PAT_BARS:  pix = {PIX_W{comp}};
      default:   pix = '0;
    endcase
  end

endmodule

// File: rtl/raster_pattern_source.sv
// Synthetic raster source: frame/line timing FSM, counters and registered pixel outputs.
//   state  | meaning
//   IDLE   | stopped, outputs 0, waits for en
//   ACTIVE | H_ACTIVE valid pixels of one line
//   HBLANK | H_BLANK idle cycles after a line, frame still valid
//   VBLANK | V_BLANK idle cycles after the last line
module raster_pattern_source
  import raster_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960,
  parameter int H_BLANK  = 160,
  parameter int V_BLANK  = 2000,
  parameter int CHK_BIT  = 5
) (
  input  logic iCLK,
  input  logic iRST,
  raster_pattern_source_if.master bus
);

  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BAR_CW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int CYC_MAX = (H_ACTIVE > H_BLANK) ? ((H_ACTIVE > V_BLANK) ? H_ACTIVE : V_BLANK)
                                                : ((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  if (H_BLANK < 1) begin : g_bad_hblank
    $error("H_BLANK must be at least 1");
  end
  if (V_BLANK < 1) begin : g_bad_vblank
    $error("V_BLANK must be at least 1");
  end
  if ((H_ACTIVE % 8) != 0) begin : g_bad_hactive
    $error("H_ACTIVE must be divisible by 8");
  end

  state_t            state;
  logic [CYC_W-1:0]  cyc;
  logic [CNT_W-1:0]  line;
  pattern_t          pat_q;
  logic [2:0]        bar_idx;
  logic [BAR_CW-1:0] bar_cnt;

  logic [PIX_W-1:0]  data_q;
  logic              dval_q;
  logic              fval_q;
  logic [CNT_W-1:0]  x_q;
  logic [CNT_W-1:0]  y_q;
  logic [15:0]       frame_q;

  logic              cyc_done;
  logic              last_line;
  logic              line_start;
  pattern_t          pat_nxt;
  logic [CNT_W-1:0]  x_nxt;
  logic [CNT_W-1:0]  y_nxt;
  logic [2:0]        bar_nxt;
  logic [BAR_CW-1:0] bar_cnt_nxt;
  logic [PIX_W-1:0]  pix_nxt;

  // Coordinates of the pixel about to be registered, so data stays aligned with x/y.
  always_comb begin
    cyc_done  = (cyc == '0);
    last_line = (line == CNT_W'(V_ACTIVE - 1));
    line_start = 1'b0;
    case (state)
      IDLE:    line_start = bus.en;
      HBLANK:  line_start = cyc_done && !last_line;
      VBLANK:  line_start = cyc_done && bus.en;
      default: line_start = 1'b0;
    endcase
    pat_nxt = (state == IDLE || state == VBLANK) ? pattern_t'(bus.pattern) : pat_q;
    y_nxt   = '0;
    if (state == HBLANK)      y_nxt = line + CNT_W'(1);
    else if (state == ACTIVE) y_nxt = line;
    x_nxt       = line_start ? '0 : x_q + CNT_W'(1);
    bar_nxt     = line_start ? 3'd0 : ((bar_cnt == '0) ? bar_idx + 3'd1 : bar_idx);
    bar_cnt_nxt = (line_start || bar_cnt == '0) ? BAR_CW'(BAR_W - 1) : bar_cnt - BAR_CW'(1);
  end

  pattern_pixel #(.CHK_BIT(CHK_BIT)) u_pixel (
    .pat     (pat_nxt),
    .x       (x_nxt),
    .y       (y_nxt),
    .bar_idx (bar_nxt),
    .pix     (pix_nxt)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state   <= IDLE;
      cyc     <= '0;
      line    <= '0;
      pat_q   <= PAT_HRAMP;
      bar_idx <= '0;
      bar_cnt <= '0;
      data_q  <= '0;
      dval_q  <= 1'b0;
      fval_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
    end else begin
      bar_idx <= bar_nxt;
      bar_cnt <= bar_cnt_nxt;
      case (state)
        IDLE: begin
          if (bus.en) begin
            state  <= ACTIVE;
            cyc    <= CYC_W'(H_ACTIVE - 1);
            pat_q  <= pat_nxt;
            line   <= '0;
            dval_q <= 1'b1;
            fval_q <= 1'b1;
            x_q    <= '0;
            y_q    <= '0;
            data_q <= pix_nxt;
          end
        end
        ACTIVE: begin
          if (cyc_done) begin
            state  <= HBLANK;
            cyc    <= CYC_W'(H_BLANK - 1);
            dval_q <= 1'b0;
            data_q <= '0;
            x_q    <= '0;
          end else begin
            cyc    <= cyc - CYC_W'(1);
            x_q    <= x_nxt;
            data_q <= pix_nxt;
          end
        end
        HBLANK: begin
          if (!cyc_done) begin
            cyc <= cyc - CYC_W'(1);
          end else if (!last_line) begin
            state  <= ACTIVE;
            cyc    <= CYC_W'(H_ACTIVE - 1);
            line   <= y_nxt;
            dval_q <= 1'b1;
            x_q    <= '0;
            y_q    <= y_nxt;
            data_q <= pix_nxt;
          end else begin
            state   <= VBLANK;
            cyc     <= CYC_W'(V_BLANK - 1);
            fval_q  <= 1'b0;
            y_q     <= '0;
            frame_q <= frame_q + 16'd1;
          end
        end
        VBLANK: begin
          if (!cyc_done) begin
            cyc <= cyc - CYC_W'(1);
          end else if (bus.en) begin
            state  <= ACTIVE;
            cyc    <= CYC_W'(H_ACTIVE - 1);
            pat_q  <= pat_nxt;
            line   <= '0;
            dval_q <= 1'b1;
            fval_q <= 1'b1;
            x_q    <= '0;
            y_q    <= '0;
            data_q <= pix_nxt;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data   = data_q;
  assign bus.dval   = dval_q;
  assign bus.fval   = fval_q;
  assign bus.x_cont = x_q;
  assign bus.y_cont = y_q;
  assign bus.frame  = frame_q;

endmodule
